count_16_monitor: RTL and testbench

- Response-side companion to the 16-bit up/down counter (count_16): observes the counter's control inputs and its Q output.
- Keeps a cycle-accurate shadow model of the counter and compares it with Q every cycle.
- Flags mismatches, counts errors, and latches the first failing expected/observed pair.
- Sits beside the counter in test_top and on-chip self-test builds; it is the reader/checker end of the counter's Data/Cnt_En/UpDown/Sclr/Q interface.

---
 rtl/count_16_monitor_pkg.sv | 31 +++
 rtl/count_16_monitor_sat_ctr.sv | 26 ++
 rtl/count_16_monitor.sv | 138 +++++++++++++
 tb/tb_count_16_monitor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_16_monitor_pkg.sv
// Shared definitions for the count_16 monitor: FSM state type, default width
// and the counter next-value rule used by both the checker and reference models.
package count_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Clear beats load, load beats counting; counting wraps modulo 2^WIDTH_DEF.
  function automatic logic [WIDTH_DEF-1:0] count_next(
    input logic [WIDTH_DEF-1:0] v,
    input logic [WIDTH_DEF-1:0] data,
    input logic                 sload,
    input logic                 en,
    input logic                 up,
    input logic                 sclr
  );
    logic [WIDTH_DEF-1:0] r;
    if (sclr)          r = '0;
    else if (sload)    r = data;
    else if (en && up) r = v + 1'b1;
    else if (en)       r = v - 1'b1;
    else               r = v;
    return r;
  endfunction

endpackage

// File: rtl/count_16_monitor_sat_ctr.sv
// Saturating up-counter: advances by one on inc_i and sticks at all-ones.
module count_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_16_monitor.sv
// Cycle-accurate checker for the count_16 up/down counter.
// Optional wrap-event counting is enabled by defining COUNT_MON_WRAP_EN.
module count_16_monitor
  import count_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ERR_W = 16,
  parameter int CHK_W = 24
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Arm,
  input  logic [WIDTH-1:0] Data,
  input  logic             Sload,
  input  logic             Cnt_En,
  input  logic             UpDown,
  input  logic             Sclr,
  input  logic [WIDTH-1:0] Q,
  output logic             Err,
  output logic [ERR_W-1:0] Err_Cnt,
  output logic [WIDTH-1:0] First_Exp,
  output logic [WIDTH-1:0] First_Got,
  output logic [CHK_W-1:0] Chk_Cnt,
  output logic             Synced,
  output logic [15:0]      Wrap_Cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] model_q, model_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;
  logic             err_inc, chk_inc;
  logic [WIDTH-1:0] next_from_q, next_from_model;

  assign next_from_q     = WIDTH'(count_next(Q, Data, Sload, Cnt_En, UpDown, Sclr));
  assign next_from_model = WIDTH'(count_next(model_q, Data, Sload, Cnt_En, UpDown, Sclr));

  always_comb begin
    state_d     = state_q;
    model_d     = model_q;
    err_d       = 1'b0;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    err_inc     = 1'b0;
    chk_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Arm) state_d = SYNC;
      end
      SYNC: begin
        // Adopt the counter's own next value so the model starts with zero skew.
        if (!Arm) begin
          state_d = IDLE;
        end else begin
          model_d = next_from_q;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!Arm) begin
          state_d = IDLE;
        end else begin
          chk_inc = 1'b1;
          if (Q != model_q) begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            if (Err_Cnt == '0) begin
              first_exp_d = model_q;
              first_got_d = Q;
            end
          end
          // Never re-sync to Q: a faulty counter keeps failing until clear/load.
          model_d = next_from_model;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      model_q     <= '0;
      err_q       <= 1'b0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      state_q     <= state_d;
      model_q     <= model_d;
      err_q       <= err_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  count_sat_ctr #(.W(ERR_W)) u_err_ctr (
    .clk_i   (Clock),
    .rst_n_i (Reset_n),
    .inc_i   (err_inc),
    .cnt_o   (Err_Cnt)
  );

  count_sat_ctr #(.W(CHK_W)) u_chk_ctr (
    .clk_i   (Clock),
    .rst_n_i (Reset_n),
    .inc_i   (chk_inc),
    .cnt_o   (Chk_Cnt)
  );

`ifdef COUNT_MON_WRAP_EN
  logic wrap_inc;

  // Only pure counting steps can wrap; clear and load never do.
  always_comb begin
    wrap_inc = 1'b0;
    if (state_q == CHECK && Arm && !Sclr && !Sload && Cnt_En) begin
      if (UpDown && (&model_q))           wrap_inc = 1'b1;
      if (!UpDown && (model_q == '0))     wrap_inc = 1'b1;
    end
  end

  count_sat_ctr #(.W(16)) u_wrap_ctr (
    .clk_i   (Clock),
    .rst_n_i (Reset_n),
    .inc_i   (wrap_inc),
    .cnt_o   (Wrap_Cnt)
  );
`else
  assign Wrap_Cnt = '0;
`endif

  assign Err       = err_q;
  assign First_Exp = first_exp_q;
  assign First_Got = first_got_q;
  assign Synced    = (state_q == CHECK);

endmodule

// File: tb/tb_count_16_monitor.sv
// Self-checking bench for count_16_monitor: an emulated (optionally faulty)
// counter drives Q while a behavioural model predicts every monitor output.
module tb_count_16_monitor;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Arm = 1'b0;
  logic [15:0] Data = '0;
  logic        Sload = 1'b0;
  logic        Cnt_En = 1'b0;
  logic        UpDown = 1'b0;
  logic        Sclr = 1'b0;
  logic [15:0] Q = '0;
  logic        Err;
  logic [15:0] Err_Cnt;
  logic [15:0] First_Exp;
  logic [15:0] First_Got;
  logic [23:0] Chk_Cnt;
  logic        Synced;
  logic [15:0] Wrap_Cnt;

  always #5 Clock = ~Clock;

  count_16_monitor dut (
    .Clock(Clock), .Reset_n(Reset_n), .Arm(Arm), .Data(Data), .Sload(Sload),
    .Cnt_En(Cnt_En), .UpDown(UpDown), .Sclr(Sclr), .Q(Q), .Err(Err),
    .Err_Cnt(Err_Cnt), .First_Exp(First_Exp), .First_Got(First_Got),
    .Chk_Cnt(Chk_Cnt), .Synced(Synced), .Wrap_Cnt(Wrap_Cnt)
  );

  int checks = 0;
  int errors = 0;

  // Emulated counter value and reference-model state.
  int          cnt = 0;
  int          phase = 0;   // consecutive armed edges since idle: 0, 1, 2+
  int          r_model = 0;
  logic        r_err = 1'b0;
  int          r_errc = 0;
  int          r_fexp = 0;
  int          r_fgot = 0;
  int          r_chk = 0;
  int          r_wrap = 0;

  logic [89:0] obs;
  assign obs = {Err, Err_Cnt, First_Exp, First_Got, Chk_Cnt, Synced, Wrap_Cnt};

  function automatic logic [89:0] exp_vec();
    logic [15:0] ec, fe, fg, wc;
    logic [23:0] cc;
    ec = 16'(r_errc); fe = 16'(r_fexp); fg = 16'(r_fgot);
    cc = 24'(r_chk);  wc = 16'(r_wrap);
    return {r_err, ec, fe, fg, cc, (phase >= 2), wc};
  endfunction

  function automatic int ref_next(int v, int d, bit sl, bit en, bit up, bit sc);
    if (sc) return 0;
    if (sl) return d;
    if (en) return up ? (v + 1) % 65536 : (v + 65535) % 65536;
    return v;
  endfunction

  // One clock: apply controls, advance the reference model and the emulated counter.
  // qx corrupts the Q shown after this edge; badprio makes the counter load over clear.
  task automatic step(input bit a, input int d, input bit sl, input bit en,
                      input bit up, input bit sc, input int qx, input bit badprio);
    int  pq;
    bit  prst;
    @(negedge Clock);
    Arm = a; Data = 16'(d); Sload = sl; Cnt_En = en; UpDown = up; Sclr = sc;
    prst = Reset_n;
    pq = int'(Q);
    @(posedge Clock);
    #1;
    if (!prst) begin
      phase = 0; r_model = 0; r_err = 0; r_errc = 0;
      r_fexp = 0; r_fgot = 0; r_chk = 0; r_wrap = 0;
    end else if (!a) begin
      phase = 0; r_err = 0;
    end else if (phase == 0) begin
      phase = 1; r_err = 0;
    end else if (phase == 1) begin
      r_model = ref_next(pq, d, sl, en, up, sc);
      phase = 2; r_err = 0;
    end else begin
      if (r_chk < 24'hFFFFFF) r_chk++;
      r_err = (pq != r_model);
      if (r_err) begin
        if (r_errc == 0) begin r_fexp = r_model; r_fgot = pq; end
        if (r_errc < 65535) r_errc++;
      end
`ifdef COUNT_MON_WRAP_EN
      if (!sc && !sl && en && ((up && r_model + 1 == 65536) || (!up && r_model == 0)))
        if (r_wrap < 65535) r_wrap++;
`endif
      r_model = ref_next(r_model, d, sl, en, up, sc);
    end
    if (badprio && sc && sl) cnt = d;
    else cnt = ref_next(cnt, d, sl, en, up, sc);
    Q = 16'(cnt) ^ 16'(qx);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 90'd0) begin
        errors++;
        $display("FAIL reset_zero cycle %0d got %h required 0", i, obs);
      end
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_release cycle %0d got %h required %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (Synced !== 1'b1) begin
      errors++;
      $display("FAIL synced_after_release got %b required 1", Synced);
    end
  endtask

  task automatic test_count_up();
    step(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 1, 1, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL count_up cycle %0d got %h required %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (Q !== 16'h0014 || Err_Cnt !== 16'd0) begin
      errors++;
      $display("FAIL count_up_end got Q=%h errcnt=%0d required Q=0014 errcnt=0", Q, Err_Cnt);
    end
  endtask

  task automatic test_wrap();
    int w0;
    int wexp;
    w0 = int'(Wrap_Cnt);
    step(1, 16'hFFFE, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 1, 0, 0, 0);
      checks++;
      if (obs !== exp_vec() || Err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_up cycle %0d got %h required %h", i, obs, exp_vec());
      end
    end
`ifdef COUNT_MON_WRAP_EN
    wexp = w0 + 1;
`else
    wexp = w0;
`endif
    checks++;
    if (int'(Wrap_Cnt) != wexp) begin
      errors++;
      $display("FAIL wrap_count got %0d required %0d", Wrap_Cnt, wexp);
    end
    // Count back down across zero.
    step(1, 16'h0001, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_down cycle %0d got %h required %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_fault();
    step(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 1, 0);        // counter reaches 4, Q shows 5
    step(1, 0, 0, 1, 1, 0, 0, 0);        // mismatch exposed at this edge
    checks++;
    if (Err !== 1'b1 || Err_Cnt !== 16'd1 || First_Exp !== 16'h0004 || First_Got !== 16'h0005) begin
      errors++;
      $display("FAIL first_fault got err=%b cnt=%0d exp=%h got=%h required 1 1 0004 0005",
               Err, Err_Cnt, First_Exp, First_Got);
    end
    step(1, 0, 0, 1, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_vec() || Err !== 1'b0) begin
      errors++;
      $display("FAIL fault_pulse got %h required %h", obs, exp_vec());
    end
    step(1, 0, 0, 0, 0, 0, 16'h0100, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (Err_Cnt !== 16'd2 || First_Exp !== 16'h0004 || First_Got !== 16'h0005) begin
      errors++;
      $display("FAIL second_fault got cnt=%0d exp=%h got=%h required 2 0004 0005",
               Err_Cnt, First_Exp, First_Got);
    end
    // A counter that slips keeps failing until a clear realigns it.
    cnt = (cnt + 7) % 65536;
    Q = 16'(cnt);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 1, (i % 2) == 0, i == 3, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL persistent cycle %0d got %h required %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_priority();
    step(1, 16'h1234, 1, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_vec() || Err !== 1'b0) begin
      errors++;
      $display("FAIL prio_good got %h required %h", obs, exp_vec());
    end
    step(1, 16'h1234, 1, 1, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_vec() || Err !== 1'b1) begin
      errors++;
      $display("FAIL prio_bad got %h required %h", obs, exp_vec());
    end
    step(1, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    Reset_n = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    Reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1, 0, 16'h0010, 0);
      step(1, 0, 0, 1, 1, 0, 0, 0);
    end
    checks++;
    if (Err_Cnt !== 16'd3 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d vec=%h required 3 %h", Err_Cnt, obs, exp_vec());
    end
    Reset_n = 1'b0;
    step(1, 0, 0, 1, 1, 0, 16'h0001, 0);
    checks++;
    if (obs !== 90'd0) begin
      errors++;
      $display("FAIL reset_mid got %h required 0", obs);
    end
    Reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (Synced !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle got synced=%b required 0", Synced);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit a;
      int qx;
      a  = ($urandom_range(0, 29) != 0);
      qx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 65535)) : 0;
      Reset_n = ($urandom_range(0, 99) != 0);
      step(a, int'($urandom_range(0, 65535)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 14) == 0, qx, $urandom_range(0, 3) == 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d got %h required %h", i, obs, exp_vec());
      end
    end
    Reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_fault();
    test_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
